// File: rtl/sram_adapter_pkg.sv
// Shared types and constants for the SRAM request adapter and its helpers.
package sram_adapter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    MERGE   = 2'd2,
    RSP     = 2'd3
  } adapter_state_e;

  localparam int DATA_WIDTH_DFLT = 32;
  localparam int BE_WIDTH        = DATA_WIDTH_DFLT / 8;
  // Byte address -> word index shift for 32-bit words.
  localparam int BYTE_OFFSET     = 2;

endpackage

// File: rtl/sram_byte_merge.sv
// Combinational per-byte select: enabled bytes come from new_data, the rest from old_data.
module sram_byte_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   new_data,
  input  logic [DATA_WIDTH-1:0]   old_data,
  output logic [DATA_WIDTH-1:0]   merged
);

  for (genvar i = 0; i < DATA_WIDTH/8; i++) begin : g_byte
    assign merged[8*i +: 8] = be[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
  end

endmodule

// File: rtl/sram_req_adapter.sv
// valid/ready front end for the single-port SRAM macro, with read-modify-write for partial stores.
// Optional SRAM_ADAPTER_FAST_RD_EN returns read data straight from the macro in RD_WAIT.
module sram_req_adapter
  import sram_adapter_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int BYTE_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [BYTE_ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH/8-1:0]    req_be,
  input  logic [DATA_WIDTH-1:0]      req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       rsp_err,
  output logic                       sram_csb0,
  output logic                       sram_web0,
  output logic [ADDR_WIDTH-1:0]      sram_addr0,
  output logic [DATA_WIDTH-1:0]      sram_din0,
  input  logic [DATA_WIDTH-1:0]      sram_dout0
);

  localparam int BEW = DATA_WIDTH / 8;

  adapter_state_e        state_q, state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BEW-1:0]        be_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  capture;

  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  oor, be_full, be_none, accept;
  logic [DATA_WIDTH-1:0] merged;
  logic                  unused_addr_lsbs;

  assign req_idx          = req_addr[ADDR_WIDTH+BYTE_OFFSET-1:BYTE_OFFSET];
  assign oor              = |req_addr[BYTE_ADDR_WIDTH-1:ADDR_WIDTH+BYTE_OFFSET];
  assign be_full          = &req_be;
  assign be_none          = ~|req_be;
  // No request is taken while reset is held, so the macro sees no strobe during reset.
  assign accept           = (state_q == IDLE) && req_valid && !rst;
  assign unused_addr_lsbs = ^req_addr[BYTE_OFFSET-1:0];

  sram_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .be       (be_q),
    .new_data (wdata_q),
    .old_data (sram_dout0),
    .merged   (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      idx_q   <= '0;
    end else begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (capture) begin
        wdata_q <= req_wdata;
        be_q    <= req_be;
        idx_q   <= req_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (oor) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RSP;
          end else if (!req_we) begin
            state_d = RD_WAIT;
          end else if (be_full || be_none) begin
            state_d = RSP;
          end else begin
            capture = 1'b1;
            state_d = MERGE;
          end
        end
      end
      RD_WAIT: begin
`ifdef SRAM_ADAPTER_FAST_RD_EN
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          rdata_d = sram_dout0;
          state_d = RSP;
        end
`else
        rdata_d = sram_dout0;
        state_d = RSP;
`endif
      end
      MERGE: state_d = RSP;
      RSP: begin
        if (rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  // Strobes are combinational; the macro registers them at the next posedge.
  always_comb begin
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_rdata  = rdata_q;
    rsp_err    = err_q;
    sram_csb0  = 1'b1;
    sram_web0  = 1'b1;
    sram_addr0 = '0;
    sram_din0  = '0;
    case (state_q)
      IDLE: begin
        req_ready = !rst;
        if (accept && !oor) begin
          if (!req_we) begin
            sram_csb0  = 1'b0;
            sram_addr0 = req_idx;
          end else if (be_full) begin
            sram_csb0  = 1'b0;
            sram_web0  = 1'b0;
            sram_addr0 = req_idx;
            sram_din0  = req_wdata;
          end else if (!be_none) begin
            sram_csb0  = 1'b0;
            sram_addr0 = req_idx;
          end
        end
      end
      RD_WAIT: begin
`ifdef SRAM_ADAPTER_FAST_RD_EN
        rsp_valid = 1'b1;
        rsp_rdata = sram_dout0;
`endif
      end
      MERGE: begin
        sram_csb0  = 1'b0;
        sram_web0  = 1'b0;
        sram_addr0 = idx_q;
        sram_din0  = merged;
      end
      RSP: rsp_valid = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sram_req_adapter.sv
// Directed bench for sram_req_adapter: macro model, transaction-level reference memory, per-cycle compare.
module tb_sram_req_adapter;

`ifdef SRAM_ADAPTER_FAST_RD_EN
  localparam int RD_LAT = 1;
`else
  localparam int RD_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        sram_csb0, sram_web0;
  logic [9:0]  sram_addr0;
  logic [31:0] sram_din0, sram_dout0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_req_adapter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_be     (req_be),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0)
  );

  // Macro: registered strobes, read data valid the cycle after the read strobe.
  logic [31:0] macro_mem [1024] = '{default: 32'h0};
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) macro_mem[sram_addr0] <= sram_din0;
      else            sram_dout0 <= macro_mem[sram_addr0];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: word memory updated at transaction level plus one expected response.
  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        partial;
    logic [9:0]  idx;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  logic [31:0] ref_mem [1024] = '{default: 32'h0};
  exp_t        exp_q[$];
  exp_t        cur;
  int          age;
  int          exp_strobes = 0;
  int          act_strobes = 0;
  int          retired = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;
  logic [9:0]  m_idx;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_csb0", 32'(sram_csb0), 32'h1);
      check("rst_web0", 32'(sram_web0), 32'h1);
      check("rst_addr0", 32'(sram_addr0), 32'h0);
      check("rst_din0", sram_din0, 32'h0);
    end else begin
      check("req_ready", 32'(req_ready), 32'(exp_q.size() == 0));
      if (exp_q.size() > 0) begin
        age++;
        cur = exp_q[0];
        if (cur.partial && age == 1) exp_strobes++;
        if (cur.partial && age == 2) begin
          for (int b = 0; b < 4; b++)
            if (cur.be[b]) ref_mem[cur.idx][8*b +: 8] = cur.wdata[8*b +: 8];
        end
        check("rsp_valid", 32'(rsp_valid), 32'(age >= cur.lat));
        if (rsp_valid) begin
          check("rsp_rdata", rsp_rdata, cur.rdata);
          check("rsp_err", 32'(rsp_err), 32'(cur.err));
          if (rsp_ready) begin
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            retired++;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("rsp_valid_idle", 32'(rsp_valid), 32'h0);
        if (!req_valid) begin
          check("idle_csb0", 32'(sram_csb0), 32'h1);
          check("idle_addr0", 32'(sram_addr0), 32'h0);
          check("idle_din0", sram_din0, 32'h0);
        end
      end
      if (!sram_csb0) act_strobes++;
      if (req_valid && req_ready) begin
        m_idx       = req_addr[11:2];
        cur.partial = 1'b0;
        cur.rdata   = 32'h0;
        cur.err     = 1'b0;
        cur.idx     = m_idx;
        cur.wdata   = req_wdata;
        cur.be      = req_be;
        cur.lat     = 1;
        if (|req_addr[31:12]) begin
          cur.err = 1'b1;
        end else if (!req_we) begin
          cur.rdata = ref_mem[m_idx];
          cur.lat   = RD_LAT;
          exp_strobes++;
        end else if (req_be == 4'hF) begin
          ref_mem[m_idx] = req_wdata;
          exp_strobes++;
        end else if (req_be != 4'h0) begin
          cur.partial = 1'b1;
          cur.lat     = 2;
          exp_strobes++;
        end
        age = 0;
        exp_q.push_back(cur);
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input int hold);
    int n;
    int start;
    start = retired;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
    rsp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (hold > 0) begin
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      repeat (hold) @(posedge clk);
      #1 rsp_ready = 1'b1;
    end
    n = 0;
    while (retired == start && n < 20) begin @(posedge clk); #1; n++; end
    if (retired == start) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout: no response retired for addr %h", addr);
    end
    rsp_ready = 1'b0;
  endtask

  int s0;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Full write then read back
    do_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0);
    check("wr_rdata_lit", last_rdata, 32'h0);
    check("wr_err_lit", 32'(last_err), 32'h0);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, 0);
    check("rd_lit", last_rdata, 32'hDEADBEEF);

    // Partial write merge
    do_req(1'b1, 32'h20, 4'hF, 32'h11223344, 0);
    do_req(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 0);
    do_req(1'b0, 32'h20, 4'h0, 32'h0, 0);
    check("merge_lit", last_rdata, 32'h11BB33DD);
    check("merge_model_lit", ref_mem[8], 32'h11BB33DD);

    // Backpressure
    do_req(1'b0, 32'h10, 4'h0, 32'h0, 5);
    check("bp_lit", last_rdata, 32'hDEADBEEF);
    check("strobes_a", 32'(act_strobes), 32'(exp_strobes));

    // Out of range: no macro access
    s0 = act_strobes;
    do_req(1'b0, 32'h1000, 4'h0, 32'h0, 0);
    check("oor_err_lit", 32'(last_err), 32'h1);
    check("oor_rdata_lit", last_rdata, 32'h0);
    check("oor_no_strobe", 32'(act_strobes), 32'(s0));

    // be = 0 write leaves the word alone
    do_req(1'b1, 32'h10, 4'h0, 32'h12345678, 0);
    do_req(1'b0, 32'h10, 4'h0, 32'h0, 0);
    check("be0_lit", last_rdata, 32'hDEADBEEF);

    // Boundary: last index and index 0
    do_req(1'b1, 32'h0FFC, 4'hF, 32'hFFFFFFFF, 0);
    do_req(1'b1, 32'h0000, 4'hF, 32'h0, 0);
    do_req(1'b0, 32'h0FFC, 4'h0, 32'h0, 0);
    check("top_lit", last_rdata, 32'hFFFFFFFF);
    do_req(1'b0, 32'h0000, 4'h0, 32'h0, 0);
    check("zero_lit", last_rdata, 32'h0);
    check("strobes_b", 32'(act_strobes), 32'(exp_strobes));

    // Reset during the merge cycle of a partial write
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_be = 4'b0011;
    req_wdata = 32'h55667788;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rmw_rst_csb0", 32'(sram_csb0), 32'h1);
    check("rmw_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_req(1'b0, 32'h20, 4'h0, 32'h0, 0);
    check("rmw_rst_word_lit", last_rdata, 32'h11BB33DD);
    check("rmw_rst_model_lit", ref_mem[8], 32'h11BB33DD);
    do_req(1'b1, 32'h24, 4'b1000, 32'hA5000000, 0);
    do_req(1'b0, 32'h24, 4'h0, 32'h0, 0);
    check("post_rst_merge_lit", last_rdata, 32'hA5000000);
    check("strobes_c", 32'(act_strobes), 32'(exp_strobes));

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sram_req_adapter.md
Name: sram_req_adapter

Overview:
- Handshake front end for the single-port 1024x32 SRAM macro. Sits between the core's load/store unit (or fetch) and the macro.
- Converts a byte-addressed valid/ready request with byte enables into macro csb0/web0/addr0/din0 strobes and returns a valid/ready response.
- The macro has no write mask, so partial-word stores use an internal read-modify-write.
- One transaction is outstanding at a time.

Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- ADDR_WIDTH, 10, macro word-address width (depth = 2**ADDR_WIDTH).
- BYTE_ADDR_WIDTH, 32, width of the byte address from the core.

Ports:
- clk  in  1  single clock; also drives macro clk0.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  adapter can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  BYTE_ADDR_WIDTH  byte address; bits [1:0] are ignored.
- req_be  in  DATA_WIDTH/8  byte enables; used only for writes.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  address out of range.
- sram_csb0  out  1  macro chip select, active low.
- sram_web0  out  1  macro write enable, active low.
- sram_addr0  out  ADDR_WIDTH  macro word address.
- sram_din0  out  DATA_WIDTH  macro write data.
- sram_dout0  in  DATA_WIDTH  macro read data; valid during the cycle after the read strobe.

Behaviour:
- Word index = req_addr[ADDR_WIDTH+1:2]. Out of range = any of req_addr[BYTE_ADDR_WIDTH-1:ADDR_WIDTH+2] nonzero.
- Macro strobes are combinational from state and request. The macro registers them at the next posedge.
- csb0 = 1 in every state/cycle not listed below.
- FSM states: IDLE, RD_WAIT, MERGE, RSP.
- IDLE: req_ready = 1. On req_valid:
  - Out of range: no macro access; set err_q = 1, rdata_q = 0; go to RSP.
  - Read: csb0 = 0, web0 = 1; go to RD_WAIT.
  - Write, be all-ones: csb0 = 0, web0 = 0, din0 = req_wdata; go to RSP.
  - Write, be = 0: no macro access; go to RSP.
  - Write, partial be: issue a macro read; latch wdata/be/word index; go to MERGE.
- RD_WAIT: rdata_q <= sram_dout0; go to RSP.
- MERGE:
  - din0 = per-byte select: byte i = be_q[i] ? wdata_q byte i : sram_dout0 byte i.
  - csb0 = 0, web0 = 0, addr0 = latched index; go to RSP.
- RSP: rsp_valid = 1; rsp_rdata = rdata_q; rsp_err = err_q. Hold until rsp_ready, then go to IDLE. rdata_q and err_q clear for the next transaction.
- req_ready = 0 in all states except IDLE, so no request is accepted in the same cycle a response retires.
- Latency from acceptance cycle N:
  - Read: rsp_valid at N+2.
  - Full write, be = 0 write, error: N+1.
  - Partial write: N+2.
- Response data and error are stable while rsp_valid = 1 and rsp_ready = 0.
- Reset (async): state = IDLE; rsp_valid = 0; rdata_q = 0; err_q = 0; csb0 = 1; web0 = 1; addr0 = 0; din0 = 0.
- Reset mid-transaction: the transaction is dropped with no response. A macro write already registered at a posedge still completes in the macro. A partial write reset in MERGE leaves the word unmodified.
- addr0 and din0 are 0 in IDLE with no request, to avoid spurious toggling.

Optional Feature:
- SRAM_ADAPTER_FAST_RD_EN
  - Defined: in RD_WAIT, rsp_valid = 1 and rsp_rdata = sram_dout0 directly, so read latency is N+1.
    - rsp_ready = 1: go to IDLE.
    - rsp_ready = 0: latch into rdata_q and go to RSP.
  - Undefined: behaviour as above, read latency N+2.

Decomposition:
- Package sram_adapter_pkg holds:
  - state enum (IDLE, RD_WAIT, MERGE, RSP);
  - localparams BE_WIDTH = DATA_WIDTH/8 and the byte-address offset of 2.
- Sub-module sram_byte_merge: purely combinational per-byte mux (be, new, old -> merged). Reused by future cache fill logic.

Test Plan:
- Full write, then read back: write addr 0x0000_0010, be=4'hF, wdata=0xDEADBEEF, rsp_ready=1 -> write rsp at N+1 with rdata=0, err=0. Read of 0x10 -> rsp_rdata=0xDEADBEEF at N+2 (N+1 with SRAM_ADAPTER_FAST_RD_EN).
- Partial write merge: preload 0x11223344 at 0x20; write be=4'b0101, wdata=0xAABBCCDD -> read returns 0x11BB33DD.
- Backpressure: read 0x10 with rsp_ready held 0 for 5 cycles -> rsp_valid and rdata=0xDEADBEEF stable; req_ready=0 throughout; no extra macro strobes.
- Out of range: read at 0x0000_1000 -> rsp_err=1, rdata=0 at N+1; sram_csb0 never low.
- Boundary and wrap: write 0xFFFF_FFFF at 0x0FFC (index 1023), then 0 at 0x0000 -> reading 0x0FFC returns 0xFFFFFFFF; index 0 is unaffected.
- Reset mid-RMW: assert rst during MERGE -> rsp_valid=0 and csb0=1 immediately; the target word keeps its old value; the next request after release is served normally.
